// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared types and helpers for the multiplexed 7-segment driver.
//            Holds the control FSM state encoding, the dash/blank segment
//            patterns, the BCD digit -> segment table and a power-of-ten
//            helper used to size the overflow limit.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}, bit 0 = a, active-high.
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Nibbles 10..15 never come out of a valid BCD conversion; they show blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential binary-to-BCD converter (shift-add-3). One value bit
//            is consumed per clock, so a conversion takes VALUE_W cycles.
// Ports    : clk, nrst      - clock, asynchronous active-low reset
//            i_start        - load i_value and clear the accumulator
//            i_value        - binary input, sampled on i_start
//            o_done         - high during the final conversion step; o_bcd is
//                             valid from the following cycle onwards
//            o_bcd          - packed BCD accumulator, nibble 0 = units
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    i_start,
    input  logic [VALUE_W-1:0]      i_value,
    output logic                    o_done,
    output logic [4*NUM_DIGITS-1:0] o_bcd
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

    logic [VALUE_W-1:0] r_sr;
    logic [BCD_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_run;
    logic [BCD_W-1:0]   w_adj;

    // Correct each nibble before the shift so that it cannot exceed 9 after
    // being doubled.
    always_comb begin
        w_adj = r_acc;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_acc[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
            end
        end
    end

    assign o_done = r_run && (r_cnt == CNT_W'(VALUE_W - 1));
    assign o_bcd  = r_acc;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sr  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_sr  <= i_value;
            r_acc <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_acc <= {w_adj[BCD_W-2:0], r_sr[VALUE_W-1]};
            r_sr  <= r_sr << 1;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Multi-digit multiplexed 7-segment driver. Converts a loaded
//            binary value to BCD, then scans the digits onto a shared segment
//            bus with one-hot anode enables. Leading-zero blanking, overflow
//            dash display and selectable output polarity.
// Ports    : clk, nrst      - clock, asynchronous active-low reset
//            i_load/i_value - display request and value (ignored while busy)
//            i_enable       - 0 forces all anodes inactive
//            i_blank_lz     - blank zero digits above the leading digit
//            o_busy         - conversion in progress
//            o_overflow     - last accepted value does not fit the display
//            o_seg          - segments {g,f,e,d,c,b,a}
//            o_an           - one-hot digit enable, bit 0 = units
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int SCAN_DIV   = 1000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_load,
    input  logic [VALUE_W-1:0]    i_value,
    input  logic                  i_enable,
    input  logic                  i_blank_lz,
    output logic                  o_busy,
    output logic                  o_overflow,
    output logic [6:0]            o_seg,
    output logic [NUM_DIGITS-1:0] o_an
);

    localparam int              BCD_W   = 4 * NUM_DIGITS;
    localparam int              IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int              DIV_W   = $clog2(SCAN_DIV);
    localparam longint unsigned c_LIMIT = pow10(NUM_DIGITS);

    state_t                r_state;
    logic                  r_busy;
    logic                  r_overflow;
    logic                  r_ovf_pend;
    logic [BCD_W-1:0]      r_disp;
    logic [DIV_W-1:0]      r_div;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;

    logic                  w_start;
    logic                  w_done;
    logic [BCD_W-1:0]      w_bcd;
    logic                  w_over;
    logic                  w_div_wrap;
    logic                  w_all_zero;
    logic [NUM_DIGITS-1:0] w_blank;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [3:0]            w_sel_digit;
    logic                  w_sel_blank;
    logic [6:0]            w_seg_next;

    // ------------------------------------------------------------------
    // Conversion control
    // ------------------------------------------------------------------
    assign w_start = (r_state == ST_IDLE) && i_load;

    // Decided at capture time so the converter's shift register can be
    // consumed freely; the flag is only published at commit.
    assign w_over = (64'(i_value) >= c_LIMIT);

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .nrst    (nrst),
        .i_start (w_start),
        .i_value (i_value),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_disp     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_load) begin
                        r_ovf_pend <= w_over;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (w_done) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_overflow <= r_ovf_pend;
                    r_disp     <= r_ovf_pend ? '0 : w_bcd;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero detection: digit k is blankable when it and every digit
    // above it are zero. Digit 0 is never blankable.
    // ------------------------------------------------------------------
    always_comb begin
        w_all_zero = 1'b1;
        w_blank    = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_all_zero = w_all_zero && (r_disp[4*k +: 4] == 4'd0);
            w_blank[k] = w_all_zero;
        end
    end

    // Digit select by comparison rather than indexing keeps the logic valid
    // for digit counts that are not a power of two.
    always_comb begin
        w_onehot    = '0;
        w_sel_digit = 4'd0;
        w_sel_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_onehot[k] = 1'b1;
                w_sel_digit = r_disp[4*k +: 4];
                w_sel_blank = w_blank[k];
            end
        end
    end

    always_comb begin
        if (r_overflow) begin
            w_seg_next = SEG_DASH;
        end else if (i_blank_lz && w_sel_blank) begin
            w_seg_next = SEG_BLANK;
        end else begin
            w_seg_next = seg_encode(w_sel_digit);
        end
    end

    // ------------------------------------------------------------------
    // Scan divider, digit index and output registers. an and seg are
    // registered in the same block so they always change together.
    // ------------------------------------------------------------------
    assign w_div_wrap = (r_div == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_div <= '0;
            r_idx <= '0;
            r_an  <= '0;
            r_seg <= '0;
        end else begin
            r_div <= w_div_wrap ? '0 : r_div + 1'b1;
            if (w_div_wrap) begin
                r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end
            r_an  <= w_onehot & {NUM_DIGITS{i_enable}};
            r_seg <= w_seg_next;
        end
    end

    // Polarity is applied after the registers; everything inside stays
    // active-high.
    generate
        if (ACTIVE_LOW) begin : g_active_low
            assign o_seg = ~r_seg;
            assign o_an  = ~r_an;
        end else begin : g_active_high
            assign o_seg = r_seg;
            assign o_an  = r_an;
        end
    endgenerate

    assign o_busy     = r_busy;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Scoreboard bench for seg7_scan_driver. Two instances (active-high
//            and active-low) share all inputs. Stimulus pushes expected
//            display frames and busy lengths into queues; monitors pop them
//            and compare against what the DUTs present.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S7 = 7'b0000111;
    localparam logic [6:0] S9 = 7'b1101111;
    localparam logic [6:0] SD = 7'b1000000;
    localparam logic [6:0] SB = 7'b0000000;

    typedef struct packed {
        logic            en;
        logic            ovf;
        logic [3:0][6:0] segs;   // segs[k] = expected pattern on digit k
    } frame_t;

    logic        clk;
    logic        nrst;
    logic        i_load;
    logic [13:0] i_value;
    logic        i_enable;
    logic        i_blank_lz;
    logic        o_busy, o_overflow;
    logic [6:0]  o_seg;
    logic [3:0]  o_an;
    logic        al_busy, al_overflow;
    logic [6:0]  al_seg;
    logic [3:0]  al_an;

    int     n_tests = 0;
    int     n_fail  = 0;
    frame_t frame_q[$];
    int     busy_q[$];
    bit     mon_busy = 0;

    seg7_scan_driver #(
        .NUM_DIGITS (4), .VALUE_W (14), .SCAN_DIV (4), .ACTIVE_LOW (1'b0)
    ) u_dut (
        .clk (clk), .nrst (nrst), .i_load (i_load), .i_value (i_value),
        .i_enable (i_enable), .i_blank_lz (i_blank_lz),
        .o_busy (o_busy), .o_overflow (o_overflow), .o_seg (o_seg), .o_an (o_an)
    );

    seg7_scan_driver #(
        .NUM_DIGITS (4), .VALUE_W (14), .SCAN_DIV (4), .ACTIVE_LOW (1'b1)
    ) u_dut_al (
        .clk (clk), .nrst (nrst), .i_load (i_load), .i_value (i_value),
        .i_enable (i_enable), .i_blank_lz (i_blank_lz),
        .o_busy (al_busy), .o_overflow (al_overflow), .o_seg (al_seg), .o_an (al_an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic frame_t mkf(input logic en, input logic ovf,
                                   input logic [6:0] s3, input logic [6:0] s2,
                                   input logic [6:0] s1, input logic [6:0] s0);
        frame_t f;
        f.en = en;
        f.ovf = ovf;
        f.segs[3] = s3;
        f.segs[2] = s2;
        f.segs[1] = s1;
        f.segs[0] = s0;
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Frame monitor: checks overflow, every digit's pattern on both
    // polarities, dwell time and scan order.
    // ------------------------------------------------------------------
    initial begin : frame_mon
        frame_t     f;
        logic [3:0] seen;
        logic [3:0] prev_an;
        logic [3:0] found;
        logic [3:0] an_inv;
        logic [6:0] seg_inv;
        logic [3:0] an_rot;
        int         run;
        int         cyc;
        int         k;
        bit         have;
        forever begin
            @(negedge clk);
            if (frame_q.size() != 0) begin
                mon_busy = 1;
                f = frame_q.pop_front();
                check("overflow", o_overflow, f.ovf);
                check("overflow_al", al_overflow, f.ovf);
                if (f.en) begin
                    seen = 4'h0; prev_an = o_an; have = 0; run = 0; cyc = 0;
                    while (seen != 4'hF && cyc < 64) begin
                        if (o_an != prev_an) begin
                            if (have) begin
                                an_rot = {prev_an[2:0], prev_an[3]};
                                check("dwell", run, 4);
                                check("an_order", o_an, an_rot);
                            end
                            have = 1;
                            run  = 1;
                        end else begin
                            run++;
                        end
                        prev_an = o_an;
                        case (o_an)
                            4'b0001: k = 0;
                            4'b0010: k = 1;
                            4'b0100: k = 2;
                            4'b1000: k = 3;
                            default: k = -1;
                        endcase
                        if (k < 0) begin
                            fail_now("an_onehot");
                        end else if (!seen[k]) begin
                            seen[k] = 1'b1;
                            an_inv  = ~(4'b0001 << k);
                            seg_inv = ~f.segs[k];
                            check($sformatf("seg_d%0d", k), o_seg, f.segs[k]);
                            check($sformatf("an_al_d%0d", k), al_an, an_inv);
                            check($sformatf("seg_al_d%0d", k), al_seg, seg_inv);
                        end
                        @(negedge clk);
                        cyc++;
                    end
                    if (seen != 4'hF) fail_now("frame_timeout");
                end else begin
                    found = 4'h0;
                    for (int c = 0; c < 16; c++) begin
                        check("an_disabled", o_an, 4'h0);
                        check("an_disabled_al", al_an, 4'hF);
                        for (int j = 0; j < 4; j++) begin
                            if (o_seg == f.segs[j]) found[j] = 1'b1;
                        end
                        @(negedge clk);
                    end
                    check("seg_tracking", found, 4'hF);
                end
                mon_busy = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy monitor: measures each busy pulse and compares to expectation.
    // ------------------------------------------------------------------
    initial begin : busy_mon
        int   len;
        logic prev;
        len = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (o_busy) begin
                len++;
            end else if (prev) begin
                if (busy_q.size() == 0) fail_now("busy_unexpected");
                else check("busy_len", len, busy_q.pop_front());
                len = 0;
            end
            prev = o_busy;
        end
    end

    task automatic do_load(input logic [13:0] v, input int exp_busy);
        @(posedge clk);
        #1;
        i_load  = 1'b1;
        i_value = v;
        busy_q.push_back(exp_busy);
        @(posedge clk);
        #1;
        i_load = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("busy_timeout");
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((frame_q.size() != 0 || mon_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_now("drain_timeout");
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_ovf"}, o_overflow, 1'b0);
        check({tag, "_an"}, o_an, 4'h0);
        check({tag, "_seg"}, o_seg, 7'h00);
        check({tag, "_an_al"}, al_an, 4'hF);
        check({tag, "_seg_al"}, al_seg, 7'h7F);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        nrst       = 1'b0;
        i_load     = 1'b0;
        i_value    = '0;
        i_enable   = 1'b1;
        i_blank_lz = 1'b1;
        #3;
        check_reset_state("reset");
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;

        // Value 0 after reset: units shows 0, upper digits blanked.
        repeat (3) @(negedge clk);
        frame_q.push_back(mkf(1, 0, SB, SB, SB, S0));
        wait_drain();

        // 1234 without blanking.
        i_blank_lz = 1'b0;
        do_load(14'd1234, 15);
        wait_idle();
        frame_q.push_back(mkf(1, 0, S1, S2, S3, S4));
        wait_drain();

        // Overflow: dashes everywhere, blanking not applied.
        i_blank_lz = 1'b1;
        do_load(14'd10000, 15);
        wait_idle();
        frame_q.push_back(mkf(1, 1, SD, SD, SD, SD));
        wait_drain();

        // 7 clears overflow; upper digits blanked.
        do_load(14'd7, 15);
        wait_idle();
        frame_q.push_back(mkf(1, 0, SB, SB, SB, S7));
        wait_drain();

        // 42, with a second load on the 3rd busy cycle that must be ignored.
        i_blank_lz = 1'b0;
        do_load(14'd42, 15);
        @(posedge clk);
        @(posedge clk);
        #1;
        i_load  = 1'b1;
        i_value = 14'd9999;
        @(posedge clk);
        #1;
        i_load = 1'b0;
        wait_idle();
        frame_q.push_back(mkf(1, 0, S0, S0, S4, S2));
        wait_drain();

        // Anodes disabled while segments keep scanning.
        @(posedge clk);
        #1 i_enable = 1'b0;
        repeat (2) @(negedge clk);
        frame_q.push_back(mkf(0, 0, S0, S0, S4, S2));
        wait_drain();
        @(posedge clk);
        #1 i_enable = 1'b1;
        repeat (2) @(negedge clk);

        // Largest displayable value.
        do_load(14'd9999, 15);
        wait_idle();
        frame_q.push_back(mkf(1, 0, S9, S9, S9, S9));
        wait_drain();

        // Inner zeros below the leading digit are never blanked.
        i_blank_lz = 1'b1;
        do_load(14'd1000, 15);
        wait_idle();
        frame_q.push_back(mkf(1, 0, S1, S0, S0, S0));
        wait_drain();

        // Set overflow, then abort a conversion of 55 with reset.
        do_load(14'd12345, 15);
        wait_idle();
        do_load(14'd55, 5);
        repeat (5) @(posedge clk);
        #1 nrst = 1'b0;
        #1;
        check_reset_state("abort");
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        i_blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        frame_q.push_back(mkf(1, 0, S0, S0, S0, S0));
        wait_drain();

        repeat (4) @(negedge clk);
        check("busy_q_empty", busy_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
